// File: rtl/lb_sched_pkg.sv
// Shared types and helpers for the rotating-BRAM line buffer scheduler.
package lb_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM
  } state_t;

  localparam int LB_DEF_HRES = 1280;
  localparam int LB_DEF_VRES = 720;
  localparam int LB_DEF_K    = 3;
  localparam int LB_DEF_LAT  = 2;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Row index of the kernel centre, wrapped into [0, vres).
  function automatic int centre_vcount(int v, int k, int vres);
    return (v + vres - (k + 1) / 2) % vres;
  endfunction

endpackage

// File: rtl/lb_sched_delay.sv
// Fixed-depth delay line; data stages only load behind a valid bit.
module lb_sched_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_prev;
  logic [WIDTH-1:0] d_q    [DEPTH];
  logic [WIDTH-1:0] d_prev [DEPTH];

  always_comb begin
    v_prev    = '0;
    v_prev[0] = valid_in;
    d_prev[0] = data_in;
    for (int i = 1; i < DEPTH; i++) begin
      v_prev[i] = v_q[i-1];
      d_prev[i] = d_q[i-1];
    end
  end

  // Idle stages keep their last captured sideband.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q <= v_prev;
      for (int i = 0; i < DEPTH; i++) begin
        if (v_prev[i]) begin
          d_q[i] <= d_prev[i];
        end
      end
    end
  end

  assign valid_out = v_q[DEPTH-1];
  assign data_out  = d_q[DEPTH-1];

endmodule

// File: rtl/line_buffer_scheduler.sv
// Bank rotation, priming and resync control for the row-BRAM line buffer.
module line_buffer_scheduler
  import lb_sched_pkg::*;
#(
  parameter int HRES         = LB_DEF_HRES,
  parameter int VRES         = LB_DEF_VRES,
  parameter int KERNEL_SIZE  = LB_DEF_K,
  parameter int BRAM_LATENCY = LB_DEF_LAT
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [$clog2(HRES)-1:0]       hcount_in,
  input  logic [$clog2(VRES)-1:0]       vcount_in,
  input  logic                          data_valid_in,
  output logic [KERNEL_SIZE:0]          bank_we_out,
  output logic [$clog2(HRES)-1:0]       bank_addr_out,
  output logic [$clog2(KERNEL_SIZE+1)-1:0] rot_sel_out,
  output logic [$clog2(HRES)-1:0]       hcount_out,
  output logic [$clog2(VRES)-1:0]       vcount_out,
  output logic                          data_valid_out,
  output logic                          primed_out,
  output logic                          resync_out
);

  localparam int NB  = KERNEL_SIZE + 1;
  localparam int HW  = $clog2(HRES);
  localparam int VW  = $clog2(VRES);
  localparam int VW1 = VW + 1;
  localparam int NBW = $clog2(NB);
  localparam int RFW = idx_w(KERNEL_SIZE + 1);
  localparam int SBW = NBW + HW + VW;

  state_t         state, state_n;
  logic [NBW-1:0] wr_ptr, wr_n;
  logic [RFW-1:0] rows_filled, rows_n;
  logic [VW-1:0]  last_vcount, last_n;
  logic           primed_q, resync_q, resync_n;
  logic           fs, lc, skip, we_en;
  logic [NBW-1:0] rot_n;
  logic [VW-1:0]  centre_v;
  logic           pipe_v;
  logic [SBW-1:0] sb_in, sb_out;

  always_comb begin
    fs   = (hcount_in == '0) && (vcount_in == '0);
    lc   = (vcount_in != last_vcount) && !fs;
    skip = lc && ({1'b0, vcount_in} != ({1'b0, last_vcount} + VW1'(1)));
  end

  // Frame start beats skip beats line change; IDLE only waits for (0,0).
  always_comb begin
    state_n  = state;
    wr_n     = wr_ptr;
    rows_n   = rows_filled;
    last_n   = last_vcount;
    resync_n = 1'b0;
    we_en    = 1'b0;
    if (data_valid_in) begin
      if (fs) begin
        state_n = PRIME;
        wr_n    = '0;
        rows_n  = '0;
        last_n  = '0;
        we_en   = 1'b1;
      end else if (state != IDLE) begin
        if (skip) begin
          state_n  = IDLE;
          resync_n = 1'b1;
        end else begin
          if (lc) begin
            wr_n = (wr_ptr == NBW'(NB - 1)) ? '0 : wr_ptr + NBW'(1);
            if (int'(rows_filled) < KERNEL_SIZE) begin
              rows_n = rows_filled + RFW'(1);
            end
            if (int'(rows_filled) + 1 >= KERNEL_SIZE) begin
              state_n = STREAM;
            end
          end
          last_n = vcount_in;
          we_en  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    bank_we_out   = we_en ? (NB'(1) << wr_n) : '0;
    bank_addr_out = hcount_in;
    rot_n         = (wr_n == NBW'(NB - 1)) ? '0 : wr_n + NBW'(1);
    centre_v      = VW'(centre_vcount(int'(vcount_in), KERNEL_SIZE, VRES));
    pipe_v        = data_valid_in && (state_n == STREAM);
    sb_in         = {rot_n, hcount_in, centre_v};
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rows_filled <= '0;
      last_vcount <= '0;
      primed_q    <= 1'b0;
      resync_q    <= 1'b0;
    end else begin
      state       <= state_n;
      wr_ptr      <= wr_n;
      rows_filled <= rows_n;
      last_vcount <= last_n;
      primed_q    <= (state_n == STREAM);
      resync_q    <= resync_n;
    end
  end

  lb_sched_delay #(
    .WIDTH(SBW),
    .DEPTH(BRAM_LATENCY)
  ) u_delay (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .valid_in (pipe_v),
    .data_in  (sb_in),
    .valid_out(data_valid_out),
    .data_out (sb_out)
  );

  assign {rot_sel_out, hcount_out, vcount_out} = sb_out;
  assign primed_out = primed_q;
  assign resync_out = resync_q;

endmodule

// File: tb/tb_line_buffer_scheduler.sv
// Randomised and directed bench for line_buffer_scheduler.
module tb_line_buffer_scheduler;

  localparam int HRES = 8;
  localparam int VRES = 6;
  localparam int K    = 3;
  localparam int LAT  = 2;
  localparam int NB   = K + 1;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [2:0] hcount_in;
  logic [2:0] vcount_in;
  logic       data_valid_in;
  logic [3:0] bank_we_out;
  logic [2:0] bank_addr_out;
  logic [1:0] rot_sel_out;
  logic [2:0] hcount_out;
  logic [2:0] vcount_out;
  logic       data_valid_out;
  logic       primed_out;
  logic       resync_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  line_buffer_scheduler #(
    .HRES(HRES), .VRES(VRES), .KERNEL_SIZE(K), .BRAM_LATENCY(LAT)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .data_valid_in (data_valid_in),
    .bank_we_out   (bank_we_out),
    .bank_addr_out (bank_addr_out),
    .rot_sel_out   (rot_sel_out),
    .hcount_out    (hcount_out),
    .vcount_out    (vcount_out),
    .data_valid_out(data_valid_out),
    .primed_out    (primed_out),
    .resync_out    (resync_out)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: frame progress in whole rows since the last (0,0).
  bit armed = 0;
  bit zero_exp = 0;
  bit m_active = 0;
  int m_rows = 0;
  int m_last = 0;
  bit m_rs = 0;
  bit p1_v = 0, p2_v = 0;
  int p1_rot, p2_rot, p1_h, p2_h, p1_cv, p2_cv;

  always @(negedge clk_in) begin
    int hh, vv;
    bit acc, rs_now;
    if (armed) begin
      if (zero_exp) begin
        chk("rst_primed", primed_out, 0);
        chk("rst_resync", resync_out, 0);
        chk("rst_dv_out", data_valid_out, 0);
        chk("rst_rot", rot_sel_out, 0);
        chk("rst_hout", hcount_out, 0);
        chk("rst_vout", vcount_out, 0);
      end else begin
        chk("primed", primed_out, m_active && m_rows >= K);
        chk("resync", resync_out, m_rs);
        chk("dv_out", data_valid_out, p2_v);
        if (p2_v) begin
          chk("rot_sel", rot_sel_out, p2_rot);
          chk("hcount_out", hcount_out, p2_h);
          chk("vcount_out", vcount_out, p2_cv);
        end
      end
    end
    if (!rst_in) begin
      m_active = 0; m_rows = 0; m_last = 0; m_rs = 0;
      p1_v = 0; p2_v = 0;
      armed = 1; zero_exp = 1;
    end else begin
      zero_exp = 0;
      hh = hcount_in;
      vv = vcount_in;
      acc = 0;
      rs_now = 0;
      if (data_valid_in) begin
        if (hh == 0 && vv == 0) begin
          m_active = 1; m_rows = 0; m_last = 0; acc = 1;
        end else if (m_active) begin
          if (vv != m_last && vv != m_last + 1) begin
            m_active = 0; rs_now = 1;
          end else begin
            if (vv != m_last) m_rows++;
            m_last = vv;
            acc = 1;
          end
        end
      end
      if (armed) begin
        chk("bank_we", bank_we_out, acc ? (1 << (m_rows % NB)) : 0);
        chk("bank_addr", bank_addr_out, hh);
      end
      m_rs = rs_now;
      p2_v = p1_v; p2_rot = p1_rot; p2_h = p1_h; p2_cv = p1_cv;
      p1_v = acc && m_active && m_rows >= K;
      p1_rot = (m_rows + 1) % NB;
      p1_h = hh;
      p1_cv = (vv + VRES - (K + 1) / 2) % VRES;
    end
  end

  task automatic drive(input int h, input int v, input bit dv);
    @(posedge clk_in);
    #1;
    hcount_in = 3'(h);
    vcount_in = 3'(v);
    data_valid_in = dv;
  endtask

  task automatic row(input int v, input int gapmax);
    for (int h = 0; h < HRES; h++) begin
      if (gapmax > 0 && $urandom_range(0, 2) == 0) begin
        int g;
        g = $urandom_range(1, gapmax);
        repeat (g) drive($urandom_range(0, 7), $urandom_range(0, 5), 0);
      end
      drive(h, v, 1);
    end
  endtask

  initial begin
    rst_in = 1'b0;
    hcount_in = '0;
    vcount_in = '0;
    data_valid_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
    drive(0, 0, 0);

    // Full frame with hand-computed pins on banks and first output.
    for (int r = 0; r < VRES; r++) begin
      drive(0, r, 1);
      #1 chk("pin_we_row", bank_we_out, 1 << (r % NB));
      if (r == 3) chk("pin_not_primed", primed_out, 0);
      drive(1, r, 1);
      if (r == 3) begin
        chk("pin_primed", primed_out, 1);
        chk("pin_dv_early", data_valid_out, 0);
      end
      drive(2, r, 1);
      if (r >= 3) begin
        chk("pin_dv_first", data_valid_out, 1);
        chk("pin_vout", vcount_out, r - 2);
      end
      for (int h = 3; h < HRES; h++) drive(h, r, 1);
    end

    // Frame wrap restarts priming at bank 0.
    for (int r = 0; r < VRES; r++) row(r, 0);

    // Row 2 followed by row 4.
    for (int r = 0; r < 3; r++) row(r, 0);
    drive(0, 4, 1);
    #1 chk("pin_skip_we", bank_we_out, 0);
    drive(1, 4, 1);
    chk("pin_resync", resync_out, 1);
    chk("pin_skip_idle", primed_out, 0);
    drive(2, 4, 1);
    chk("pin_resync_once", resync_out, 0);
    for (int h = 3; h < HRES; h++) drive(h, 4, 1);
    row(5, 0);

    // Random gaps inside rows.
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < VRES; r++) row(r, 5);

    // Reset mid row 3 while streaming.
    for (int r = 0; r < 3; r++) row(r, 0);
    for (int h = 0; h < 4; h++) drive(h, 3, 1);
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    hcount_in = 3'd4;
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    chk("pin_rst_primed", primed_out, 0);
    chk("pin_rst_dv", data_valid_out, 0);
    chk("pin_rst_rot", rot_sel_out, 0);
    for (int h = 5; h < HRES; h++) drive(h, 3, 1);
    row(4, 0);
    row(5, 0);
    for (int r = 0; r < VRES; r++) row(r, 0);

    // Random frames with occasional skipped lines.
    for (int f = 0; f < 6; f++) begin
      for (int r = 0; r < VRES; r++) begin
        int v;
        v = r;
        if (r > 0 && r < VRES - 1 && $urandom_range(0, 9) == 0) v = r + 1;
        row(v, $urandom_range(0, 3));
      end
    end

    repeat (4) drive(0, 0, 0);
    @(negedge clk_in);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
